// File: rtl/reg_scoreboard.sv
// Register hazard scoreboard between id and ex: one pending-write bit per GPR,
// RAW/WAW stall generation, writeback clearing, and a saturating stall counter.
module reg_scoreboard #(
  parameter int NUM_REGS  = 32,
  parameter int ADDR_W    = 5,
  parameter int CNT_W     = 16,
  parameter int WB_BYPASS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid_i,
  input  logic                reg1_re_i,
  input  logic [ADDR_W-1:0]   reg1_raddr_i,
  input  logic                reg2_re_i,
  input  logic [ADDR_W-1:0]   reg2_raddr_i,
  input  logic                reg_we_i,
  input  logic [ADDR_W-1:0]   reg_waddr_i,
  input  logic                ex_ready_i,
  input  logic                wb_we_i,
  input  logic [ADDR_W-1:0]   wb_waddr_i,
  input  logic                flush_i,
  output logic                issue_ready_o,
  output logic                stall_o,
  output logic [NUM_REGS-1:0] pending_o,
  output logic                busy_o,
  output logic                wb_err_o,
  output logic [CNT_W-1:0]    stall_cnt_o
);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic                wb_err_q, wb_err_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  // One-hot decodes; bit 0 is never set so x0 can neither hazard nor be tracked.
  logic [NUM_REGS-1:0] rd1_sel, rd2_sel, wr_sel, wb_sel;
  logic [NUM_REGS-1:0] eff_pending;
  logic                haz, fire, wb_hit_pending;

  always_comb begin
    rd1_sel = '0;
    rd2_sel = '0;
    wr_sel  = '0;
    wb_sel  = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      rd1_sel[r] = reg1_re_i && (reg1_raddr_i == ADDR_W'(r));
      rd2_sel[r] = reg2_re_i && (reg2_raddr_i == ADDR_W'(r));
      wr_sel[r]  = reg_we_i  && (reg_waddr_i  == ADDR_W'(r));
      wb_sel[r]  = wb_we_i   && (wb_waddr_i   == ADDR_W'(r));
    end
  end

  always_comb begin
    if (WB_BYPASS != 0) begin
      eff_pending = pending_q & ~wb_sel;
    end else begin
      eff_pending = pending_q;
    end
    haz            = |((rd1_sel | rd2_sel | wr_sel) & eff_pending);
    wb_hit_pending = |(wb_sel & pending_q);
  end

  assign issue_ready_o = ex_ready_i && !haz && !flush_i;
  assign fire          = id_valid_i && issue_ready_o;
  assign stall_o       = id_valid_i && !issue_ready_o;

  // Priority per register: flush, then issue set, then writeback clear.
  always_comb begin
    pending_d = pending_q;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (flush_i) begin
        pending_d[r] = 1'b0;
      end else if (fire && wr_sel[r]) begin
        pending_d[r] = 1'b1;
      end else if (wb_sel[r]) begin
        pending_d[r] = 1'b0;
      end
    end
    pending_d[0] = 1'b0;
  end

  // Addresses outside the register file never match, so they are flagged too.
  assign wb_err_d = wb_we_i && (wb_waddr_i != '0) && !wb_hit_pending && !flush_i;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= '0;
      wb_err_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      pending_q   <= pending_d;
      wb_err_q    <= wb_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pending_o   = pending_q;
  assign busy_o      = |pending_q;
  assign wb_err_o    = wb_err_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them. Instance a: defaults; instance b: no bypass, 4-bit counter.
module tb_reg_scoreboard;

  localparam int A_IR = 0, A_ST = 1, A_PEND = 2, A_BUSY = 3, A_ERR = 4, A_CNT = 5;
  localparam int B_IR = 6, B_ST = 7, B_PEND = 8, B_CNT = 9, B_ERR = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic a_id_valid, a_re1, a_re2, a_we, a_ex_ready, a_wb_we, a_flush;
  logic [4:0] a_ra1, a_ra2, a_wa, a_wba;
  logic a_ir, a_st, a_busy, a_err;
  logic [31:0] a_pend;
  logic [15:0] a_cnt;

  logic b_id_valid, b_re1, b_re2, b_we, b_ex_ready, b_wb_we, b_flush;
  logic [4:0] b_ra1, b_ra2, b_wa, b_wba;
  logic b_ir, b_st, b_busy, b_err;
  logic [31:0] b_pend;
  logic [3:0] b_cnt;

  reg_scoreboard dut_a (
    .clk(clk), .rst(rst), .id_valid_i(a_id_valid),
    .reg1_re_i(a_re1), .reg1_raddr_i(a_ra1), .reg2_re_i(a_re2), .reg2_raddr_i(a_ra2),
    .reg_we_i(a_we), .reg_waddr_i(a_wa), .ex_ready_i(a_ex_ready),
    .wb_we_i(a_wb_we), .wb_waddr_i(a_wba), .flush_i(a_flush),
    .issue_ready_o(a_ir), .stall_o(a_st), .pending_o(a_pend), .busy_o(a_busy),
    .wb_err_o(a_err), .stall_cnt_o(a_cnt)
  );

  reg_scoreboard #(.CNT_W(4), .WB_BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .id_valid_i(b_id_valid),
    .reg1_re_i(b_re1), .reg1_raddr_i(b_ra1), .reg2_re_i(b_re2), .reg2_raddr_i(b_ra2),
    .reg_we_i(b_we), .reg_waddr_i(b_wa), .ex_ready_i(b_ex_ready),
    .wb_we_i(b_wb_we), .wb_waddr_i(b_wba), .flush_i(b_flush),
    .issue_ready_o(b_ir), .stall_o(b_st), .pending_o(b_pend), .busy_o(b_busy),
    .wb_err_o(b_err), .stall_cnt_o(b_cnt)
  );

  typedef struct {
    int          cyc;
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] get_val(int sel);
    case (sel)
      A_IR:   return {31'b0, a_ir};
      A_ST:   return {31'b0, a_st};
      A_PEND: return a_pend;
      A_BUSY: return {31'b0, a_busy};
      A_ERR:  return {31'b0, a_err};
      A_CNT:  return {16'b0, a_cnt};
      B_IR:   return {31'b0, b_ir};
      B_ST:   return {31'b0, b_st};
      B_PEND: return b_pend;
      B_CNT:  return {28'b0, b_cnt};
      B_ERR:  return {31'b0, b_err};
      default: return 32'hdead_beef;
    endcase
  endfunction

  // Monitor: compare every expectation tagged for the current cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        logic [31:0] got;
        got = get_val(sb[i].sel);
        n_chk++;
        if (got === sb[i].val) n_pass++;
        else $display("FAIL %s @cyc%0d: got 0x%0h expected 0x%0h", sb[i].name, cyc, got, sb[i].val);
        sb.delete(i);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got cyc=%0d expected < 70000", cyc);
    $fatal(1, "watchdog");
  end

  task automatic exp(int d, string nm, int sel, logic [31:0] v);
    exp_t e;
    e.cyc = cyc + d; e.name = nm; e.sel = sel; e.val = v;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    a_id_valid = 0; a_re1 = 0; a_ra1 = 0; a_re2 = 0; a_ra2 = 0;
    a_we = 0; a_wa = 0; a_ex_ready = 1; a_wb_we = 0; a_wba = 0; a_flush = 0;
  endtask

  task automatic idle_b();
    b_id_valid = 0; b_re1 = 0; b_ra1 = 0; b_re2 = 0; b_ra2 = 0;
    b_we = 0; b_wa = 0; b_ex_ready = 1; b_wb_we = 0; b_wba = 0; b_flush = 0;
  endtask

  initial begin
    idle_a(); idle_b();
    rst = 1;
    tick(); tick();
    rst = 0;

    n_chk++;
    if (a_pend === 32'h0) n_pass++;
    else $display("FAIL d_rst_pend: got 0x%0h expected 0x0", a_pend);
    n_chk++;
    if (a_cnt === 16'h0) n_pass++;
    else $display("FAIL d_rst_cnt: got 0x%0h expected 0x0", a_cnt);
    n_chk++;
    if (a_err === 1'b0) n_pass++;
    else $display("FAIL d_rst_err: got %0b expected 0", a_err);
    n_chk++;
    if (a_ir === 1'b1) n_pass++;
    else $display("FAIL d_rst_ir: got %0b expected 1", a_ir);
    n_chk++;
    if (b_pend === 32'h0) n_pass++;
    else $display("FAIL d_rst_b_pend: got 0x%0h expected 0x0", b_pend);
    n_chk++;
    if (b_ir === 1'b1) n_pass++;
    else $display("FAIL d_rst_b_ir: got %0b expected 1", b_ir);

    // Reset state
    exp(0, "rst_pend", A_PEND, 0); exp(0, "rst_cnt", A_CNT, 0); exp(0, "rst_err", A_ERR, 0);
    exp(0, "rst_busy", A_BUSY, 0); exp(0, "rst_ir", A_IR, 1); exp(0, "rst_stall", A_ST, 0);
    exp(0, "rst_b_pend", B_PEND, 0); exp(0, "rst_b_cnt", B_CNT, 0); exp(0, "rst_b_ir", B_IR, 1);

    // RAW on x5 with same-cycle bypassed writeback
    a_id_valid = 1; a_we = 1; a_wa = 5;
    exp(0, "iss5_ir", A_IR, 1); exp(1, "iss5_pend", A_PEND, 32'h20); exp(1, "iss5_busy", A_BUSY, 1);
    tick();
    idle_a(); a_id_valid = 1; a_re1 = 1; a_ra1 = 5;
    exp(0, "raw5_stall", A_ST, 1); exp(0, "raw5_ir", A_IR, 0);
    exp(1, "raw5_cnt", A_CNT, 1); exp(1, "raw5_pend", A_PEND, 32'h20);
    tick();
    a_wb_we = 1; a_wba = 5;
    exp(0, "byp5_ir", A_IR, 1); exp(0, "byp5_stall", A_ST, 0);
    exp(1, "byp5_pend", A_PEND, 0); exp(1, "byp5_cnt", A_CNT, 1); exp(1, "byp5_err", A_ERR, 0);
    tick();

    // Set beats clear on x7
    idle_a(); a_id_valid = 1; a_we = 1; a_wa = 7;
    exp(1, "set7_pend", A_PEND, 32'h80);
    tick();
    a_wb_we = 1; a_wba = 7;
    exp(0, "waw7_ir", A_IR, 1); exp(1, "waw7_pend", A_PEND, 32'h80); exp(1, "waw7_err", A_ERR, 0);
    tick();
    idle_a(); a_wb_we = 1; a_wba = 7;
    exp(1, "clr7_pend", A_PEND, 0); exp(1, "clr7_err", A_ERR, 0);
    tick();

    // x0 never hazards nor tracks
    idle_a(); a_id_valid = 1; a_we = 1; a_wa = 0; a_re1 = 1; a_ra1 = 0; a_wb_we = 1; a_wba = 0;
    exp(0, "x0_ir", A_IR, 1); exp(1, "x0_pend", A_PEND, 0); exp(1, "x0_err", A_ERR, 0);
    tick();

    // Writeback to a non-pending register
    idle_a(); a_wb_we = 1; a_wba = 12;
    exp(1, "err12", A_ERR, 1);
    tick();
    idle_a();
    exp(1, "err12_pulse", A_ERR, 0);
    tick();

    // Flush clears 3, 9, 31
    a_id_valid = 1; a_we = 1; a_wa = 3; tick();
    a_wa = 9; tick();
    a_wa = 31;
    exp(1, "set3931_pend", A_PEND, 32'h8000_0208);
    tick();
    a_flush = 1; a_wa = 20; a_wb_we = 1; a_wba = 3;
    exp(0, "flush_ir", A_IR, 0); exp(0, "flush_stall", A_ST, 1);
    exp(1, "flush_pend", A_PEND, 0); exp(1, "flush_err", A_ERR, 0); exp(1, "flush_cnt", A_CNT, 2);
    tick();
    idle_a(); a_wb_we = 1; a_wba = 9;
    exp(0, "post_flush_busy", A_BUSY, 0); exp(1, "post_flush_err", A_ERR, 1);
    tick();
    idle_a();
    exp(1, "post_flush_pulse", A_ERR, 0);
    tick();

    // ex not ready stalls
    a_id_valid = 1; a_ex_ready = 0;
    exp(0, "exnr_ir", A_IR, 0); exp(0, "exnr_stall", A_ST, 1); exp(1, "exnr_cnt", A_CNT, 3);
    tick();

    // Source-2 hazard, and read enable gating
    idle_a(); a_id_valid = 1; a_we = 1; a_wa = 10;
    exp(1, "set10_pend", A_PEND, 32'h400);
    tick();
    idle_a(); a_id_valid = 1; a_re2 = 1; a_ra2 = 10;
    exp(0, "raw2_stall", A_ST, 1); exp(1, "raw2_cnt", A_CNT, 4);
    tick();
    idle_a(); a_id_valid = 1; a_re2 = 0; a_ra2 = 10; a_re1 = 1; a_ra1 = 0;
    exp(0, "re_gate_ir", A_IR, 1); exp(0, "re_gate_cnt", A_CNT, 4);
    tick();

    // Long hazard to saturate the 16-bit counter
    idle_a(); a_id_valid = 1; a_re1 = 1; a_ra1 = 10;
    for (int k = 0; k < 65530; k++) tick();
    exp(0, "sat_pre", A_CNT, 16'hfffe);
    for (int k = 0; k < 9; k++) tick();
    exp(0, "sat", A_CNT, 16'hffff);
    n_chk++;
    if (a_cnt === 16'hffff) n_pass++;
    else $display("FAIL d_sat: got 0x%0h expected 0xffff", a_cnt);
    idle_a(); a_wb_we = 1; a_wba = 10;
    exp(1, "sat_hold", A_CNT, 16'hffff); exp(1, "end10_pend", A_PEND, 0);
    tick();
    idle_a();

    // Instance b: no writeback bypass
    b_id_valid = 1; b_we = 1; b_wa = 6;
    exp(1, "b_set6", B_PEND, 32'h40);
    tick();
    idle_b(); b_id_valid = 1; b_re1 = 1; b_ra1 = 6; b_wb_we = 1; b_wba = 6;
    exp(0, "b_nobyp_ir", B_IR, 0); exp(0, "b_nobyp_stall", B_ST, 1);
    exp(1, "b_clr6", B_PEND, 0); exp(1, "b_cnt1", B_CNT, 1);
    tick();
    b_wb_we = 0;
    exp(0, "b_late_ir", B_IR, 1); exp(0, "b_late_stall", B_ST, 0);
    tick();
    idle_b(); b_id_valid = 1; b_we = 1; b_wa = 8;
    exp(1, "b_set8", B_PEND, 32'h100);
    tick();
    b_wb_we = 1; b_wba = 8;
    exp(0, "b_waw_ir", B_IR, 0); exp(1, "b_waw_pend", B_PEND, 0); exp(1, "b_cnt2", B_CNT, 2);
    tick();
    b_wb_we = 0;
    exp(0, "b_waw_late_ir", B_IR, 1); exp(1, "b_reset8", B_PEND, 32'h100);
    tick();
    idle_b(); b_id_valid = 1; b_re2 = 1; b_ra2 = 8;
    for (int k = 0; k < 12; k++) tick();
    exp(0, "b_sat_pre", B_CNT, 14);
    for (int k = 0; k < 7; k++) tick();
    exp(0, "b_sat", B_CNT, 15);
    n_chk++;
    if (b_cnt === 4'hf) n_pass++;
    else $display("FAIL d_b_sat: got 0x%0h expected 0xf", b_cnt);
    idle_b(); b_flush = 1;
    exp(1, "b_flush_pend", B_PEND, 0); exp(1, "b_flush_err", B_ERR, 0);
    tick();
    idle_b(); b_wb_we = 1; b_wba = 8;
    exp(1, "b_post_flush_err", B_ERR, 1);
    tick();
    idle_b();
    exp(1, "b_err_pulse", B_ERR, 0);
    tick();

    tick(); tick();
    foreach (sb[i]) begin
      n_chk++;
      $display("FAIL %s: got no comparison expected one at cyc%0d", sb[i].name, sb[i].cyc);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
